// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if: bundle of LED controller mode/level/touch inputs and pressed/pwm/tick outputs
// Ports: master drives mode_i, level_i, touch_n and observes pressed_o, pwm_o, tick_o; slave is the reverse
interface led_pattern_ctrl_if #(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8
);
  logic [2*CHANNELS-1:0] mode_i;
  logic [PWM_BITS*CHANNELS-1:0] level_i;
  logic [CHANNELS-1:0] touch_n;
  logic [CHANNELS-1:0] pressed_o;
  logic [CHANNELS-1:0] pwm_o;
  logic tick_o;
  modport master (output mode_i, level_i, touch_n, input pressed_o, pwm_o, tick_o);
  modport slave (input mode_i, level_i, touch_n, output pressed_o, pwm_o, tick_o);
endinterface

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: per-channel LED PWM with off/touch/blink/breathe modes and debounced touch inputs
// Ports: clki clock, rst synchronous active-high reset,
//        bus (slave): mode_i/level_i/touch_n in, pressed_o/pwm_o/tick_o out
module led_pattern_ctrl #(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8,
  parameter int LOG2DELAY = 21,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic clki,
  input  logic rst,
  led_pattern_ctrl_if.slave bus
);
  localparam int TB = LOG2DELAY - PWM_BITS;
  logic [PWM_BITS-1:0] pcnt_q, r_q, r_d;
  logic [LOG2DELAY-1:0] phase_q;
  logic blink_q, up_q, tick_q, step;
  logic [CHANNELS-1:0] s1_q, s2_q, pressed_q, pwm_q, mis;
  logic [DEBOUNCE_BITS-1:0] db_q [CHANNELS];
  logic [PWM_BITS-1:0] duty_q [CHANNELS];
  logic [PWM_BITS-1:0] duty_d [CHANNELS];
  assign step = &phase_q[TB-1:0];
  assign r_d = up_q ? r_q + 1'b1 : r_q - 1'b1;
  // synchronised touch_n equal to pressed_o means the line disagrees with the debounced state
  assign mis = ~(s2_q ^ pressed_q);
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [PWM_BITS-1:0] lvl;
    logic [1:0] m;
    logic [2*PWM_BITS-1:0] prod;
    assign lvl = bus.level_i[PWM_BITS*k +: PWM_BITS];
    assign m = bus.mode_i[2*k +: 2];
    assign prod = {{PWM_BITS{1'b0}}, r_q} * {{PWM_BITS{1'b0}}, lvl};
    assign duty_d[k] = m == 2'b11 ? prod[2*PWM_BITS-1:PWM_BITS]
                     : (m == 2'b01 && pressed_q[k]) || (m == 2'b10 && blink_q) ? lvl : '0;
  end
  always_ff @(posedge clki) begin
    if (rst) begin
      pcnt_q <= '0;
      phase_q <= '0;
      r_q <= '0;
      up_q <= 1'b1;
      blink_q <= 1'b0;
      tick_q <= 1'b0;
      s1_q <= '1;
      s2_q <= '1;
      pressed_q <= '0;
      pwm_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i] <= '0;
        db_q[i] <= '0;
      end
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
      phase_q <= phase_q + 1'b1;
      blink_q <= blink_q ^ (&phase_q);
      tick_q <= step;
      // triangle ramp: direction flips on the step that lands on an end value
      if (step) begin
        r_q <= r_d;
        up_q <= up_q ? ~&r_d : ~|r_d;
      end
      s1_q <= bus.touch_n;
      s2_q <= s1_q;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_q[i] <= pcnt_q < duty_q[i];
        // duty only moves at the period boundary so pwm_o never glitches mid-period
        if (&pcnt_q) duty_q[i] <= duty_d[i];
        db_q[i] <= mis[i] && !(&db_q[i]) ? db_q[i] + 1'b1 : '0;
        if (mis[i] && &db_q[i]) pressed_q[i] <= ~pressed_q[i];
      end
    end
  end
  assign bus.pressed_o = pressed_q;
  assign bus.pwm_o = pwm_q;
  assign bus.tick_o = tick_q;
endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent LED channels.
REQ-002 SHALL have parameter PWM_BITS, default 8: PWM counter, level and ramp width.
REQ-003 SHALL have parameter LOG2DELAY, default 21: the blink half-period is 2**LOG2DELAY cycles; LOG2DELAY > PWM_BITS is required.
REQ-004 SHALL have parameter DEBOUNCE_BITS, default 16: the debounce hold is 2**DEBOUNCE_BITS cycles.
REQ-005 SHALL have port clki  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-007 SHALL have port mode_i  in  2*CHANNELS  per-channel mode: 00 off, 01 touch, 10 blink, 11 breathe (ch k at [2k+1:2k]).
REQ-008 SHALL have port level_i  in  PWM_BITS*CHANNELS  per-channel peak duty (ch k at [PWM_BITS*k +: PWM_BITS]).
REQ-009 SHALL have port touch_n  in  CHANNELS  per-channel active-low pulled-up touch input, asynchronous.
REQ-010 SHALL have port pressed_o  out  CHANNELS  debounced touch state, 1 = pressed.
REQ-011 SHALL have port pwm_o  out  CHANNELS  registered PWM drive to the RGBA driver PWM inputs.
REQ-012 SHALL have port tick_o  out  1  one-cycle pulse on each breathe ramp step.

Function
REQ-013 SHALL keep one shared free-running PWM_BITS counter pcnt that increments every cycle and wraps from all-ones to 0.
REQ-014 SHALL keep one shared free-running LOG2DELAY-bit phase counter.
REQ-015 SHALL toggle the shared blink state each time the phase counter wraps; blink state is 0 after reset.
REQ-016 SHALL pulse tick_o for the single cycle in which phase[LOG2DELAY-PWM_BITS-1:0] is all-ones.
REQ-017 SHALL, on each tick, step the shared ramp r as a triangle: UP increments r, and r reaching all-ones switches to DOWN; DOWN decrements r, and r reaching 0 switches to UP; r never wraps.
REQ-018 SHALL compute the target duty per channel as: off -> 0; touch -> level if pressed_o else 0; blink -> level if blink state is 1 else 0; breathe -> (r*level)>>PWM_BITS, using a 2*PWM_BITS-wide product truncated to PWM_BITS.
REQ-019 SHALL latch the target into a per-channel duty register only in the cycle where pcnt is all-ones, so mode_i and level_i changes take effect at the next PWM period with no glitch.
REQ-020 SHALL register pwm_o[k] = 1 when pcnt < duty[k], with latency 1 cycle; duty 0 gives constant 0; duty all-ones gives 1 for 2**PWM_BITS-1 of every 2**PWM_BITS cycles.
REQ-021 SHALL synchronise each touch_n through two flops before use.
REQ-022 SHALL have a per-channel debounce counter that clears whenever the synchronised value equals the current state (state = ~pressed_o).
REQ-023 SHALL increment the debounce counter on a mismatch; on reaching all-ones while still mismatched, it SHALL flip pressed_o and clear.
REQ-024 SHALL treat a glitch shorter than 2**DEBOUNCE_BITS cycles as producing no change on pressed_o.
REQ-025 SHALL keep channels fully independent apart from the shared pcnt, phase and ramp; mode changes SHALL NOT restart the shared counters.
REQ-026 SHALL run pcnt, phase and ramp free regardless of mode_i.

Reset
REQ-027 SHALL, while rst is high at a clock edge, clear pcnt, phase, r, blink state, all duty registers, pwm_o, tick_o, pressed_o and the debounce counters.
REQ-028 SHALL, under reset, set the ramp direction to UP and the synchroniser flops to 1 (released).
REQ-029 SHALL, when rst is asserted mid-operation, return all outputs to 0 at the next edge; on release, counting restarts from 0, so the first duty latch occurs 2**PWM_BITS-1 cycles after release.

Verification (PWM_BITS=4, LOG2DELAY=6, DEBOUNCE_BITS=2, CHANNELS=3)
REQ-030 SHALL cover: ch0 mode 01, level 8, touch_n[0] low for 10 cycles -> pressed_o[0] rises 6 cycles after the edge (2 sync + 4 debounce); pwm_o[0] high 8 of every 16 cycles from the next period.
REQ-031 SHALL cover: touch_n[1] low pulse of 3 cycles in mode 01 -> pressed_o[1] stays 0 and pwm_o[1] stays 0.
REQ-032 SHALL cover: ch2 mode 10, level 15 -> pwm_o[2] high 15/16 during blink-on, constant 0 during blink-off; blink state toggles every 64 cycles.
REQ-033 SHALL cover: ch0 mode 11, level 15 -> tick_o every 4 cycles; r rises 0..15, then falls 15..0; duty tracks (r*15)>>4 and updates only at pcnt=15.
REQ-034 SHALL cover: ch1 switched from 10 to 00 mid-period -> pwm_o[1] keeps the old duty until pcnt=15, then stays 0.
REQ-035 SHALL cover: rst pulsed for 1 cycle mid-breathe -> pwm_o=0, tick_o=0 and pressed_o=0 next cycle; the first tick occurs 4 cycles after release.
